// File: rtl/spike_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spike_arbiter_pkg
// Shared definitions for the spike arbiter and its scan-pointer helper:
//   - spike code values carried on the two-bit code field
//   - default bus widths (code width, neuron id width, broadcast word width)
//   - arbiter FSM state encoding
//   - a small helper that classifies a code as a real (firing) spike
// ---------------------------------------------------------------------------
package spike_arbiter_pkg;

  // Default widths; the top module exposes these as overridable parameters.
  localparam int TEN_DATA_WIDTH  = 2;
  localparam int NEURON_ID_WIDTH = 9;
  localparam int NUM_NEURON      = 512;
  localparam int SPIKE_IN_WIDTH  = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

  // Spike codes. Code 3 is reserved/invalid and is treated like "no spike".
  localparam logic [1:0] SPIKE_NONE = 2'd0;
  localparam logic [1:0] SPIKE_POS  = 2'd1;
  localparam logic [1:0] SPIKE_NEG  = 2'd2;
  localparam logic [1:0] SPIKE_INV  = 2'd3;

  // Arbiter FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // True for codes that represent an actual spike worth broadcasting.
  function automatic logic is_fire(input logic [1:0] code);
    return (code == SPIKE_POS) || (code == SPIKE_NEG);
  endfunction

endpackage

// File: rtl/rr_scan_ptr.sv
// ---------------------------------------------------------------------------
// rr_scan_ptr
// Round-robin scan bookkeeping for the spike arbiter.
//   clk, reset   : clock, asynchronous active-high reset
//   eff_active   : number of neurons taking part (already clamped to the array)
//   load         : start a new scan; ptr <- start (or 0 if start is out of
//                  range), cnt <- 0
//   step         : current entry missed; advance ptr (wrapping) and cnt
//   hit          : current entry won; next round starts just after it
//   ptr          : index currently being examined
//   exhausted    : the current entry is the last one of this round's scan
// ---------------------------------------------------------------------------
module rr_scan_ptr #(
  parameter int ID_W = spike_arbiter_pkg::NEURON_ID_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W:0]   eff_active,
  input  logic            load,
  input  logic            step,
  input  logic            hit,
  output logic [ID_W-1:0] ptr,
  output logic            exhausted
);
  import spike_arbiter_pkg::*;

  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] start_reg;
  logic [ID_W:0]   cnt_reg;

  logic [ID_W:0]   ptr_inc;
  logic [ID_W-1:0] ptr_wrapped;
  logic [ID_W-1:0] start_load;

  // One extra bit so ptr+1 never overflows before the wrap compare.
  assign ptr_inc     = {1'b0, ptr_reg} + {{ID_W{1'b0}}, 1'b1};
  assign ptr_wrapped = (ptr_inc >= eff_active) ? '0 : ptr_inc[ID_W-1:0];

  // The active population may have shrunk since the start pointer was
  // recorded; in that case the scan restarts from neuron 0.
  assign start_load  = ({1'b0, start_reg} >= eff_active) ? '0 : start_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg   <= '0;
      start_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      if (load) begin
        ptr_reg <= start_load;
        cnt_reg <= '0;
      end else if (step) begin
        ptr_reg <= ptr_wrapped;
        cnt_reg <= cnt_reg + {{ID_W{1'b0}}, 1'b1};
      end
      if (hit) begin
        start_reg <= ptr_wrapped;
      end
    end
  end

  // eff_active = 0 is never scanned (the arbiter short-circuits it), so the
  // underflow of eff_active-1 in that case is harmless.
  assign exhausted = (cnt_reg == (eff_active - {{ID_W{1'b0}}, 1'b1}));
  assign ptr       = ptr_reg;

endmodule

// File: rtl/spike_arbiter.sv
// ---------------------------------------------------------------------------
// spike_arbiter
// Network-side arbiter for the neuron array. Each round it snapshots every
// neuron's spike code, picks at most one firing neuron by round-robin scan
// and broadcasts it to all neurons, then pulses networkDone.
//   clk           : system clock
//   reset         : asynchronous active-high reset
//   en_network    : round request (level); a new round needs a fall and rise
//   spikes_in     : flat spike codes, neuron i at [TEN*i +: TEN]
//   active_neuron : number of neurons in use (scan covers 0..active-1)
//   spike_out     : broadcast word {code, neuron_id}; zero when no winner
//   networkDone   : one-cycle round-complete pulse
//   winner_valid  : spike_out carries a real spike
//   busy          : arbiter is not idle
// ---------------------------------------------------------------------------
module spike_arbiter #(
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = 9
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en_network,
  input  logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]  spikes_in,
  input  logic [NEURON_ID_WIDTH-1:0]            active_neuron,
  output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_out,
  output logic                                  networkDone,
  output logic                                  winner_valid,
  output logic                                  busy
);
  import spike_arbiter_pkg::*;

  localparam int OUT_W = TEN_DATA_WIDTH + NEURON_ID_WIDTH;
  localparam logic [NEURON_ID_WIDTH:0] NUM_EFF = (NEURON_ID_WIDTH + 1)'(NUM_NEURON);

  // ------------------------------------------------------------------
  // Effective population: active_neuron clamped to the physical array.
  // ------------------------------------------------------------------
  logic [NEURON_ID_WIDTH:0] active_ext;
  logic [NEURON_ID_WIDTH:0] eff_active;
  logic                     scan_empty;

  assign active_ext = {1'b0, active_neuron};
  assign eff_active = (active_ext > NUM_EFF) ? NUM_EFF : active_ext;
  assign scan_empty = (eff_active == '0);

  // ------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [OUT_W-1:0] spike_out_reg;
  logic             networkDone_reg;
  logic             winner_valid_reg;
  logic             busy_reg;

  // Scan control
  logic                       load;
  logic                       step;
  logic                       hit_take;
  logic [NEURON_ID_WIDTH-1:0] ptr;
  logic                       exhausted;

  // ------------------------------------------------------------------
  // Snapshot of all spike codes, captured once when a round is accepted.
  // Later changes on spikes_in do not affect the ongoing scan.
  // ------------------------------------------------------------------
  logic [TEN_DATA_WIDTH-1:0] snap_reg [NUM_NEURON];
  logic [TEN_DATA_WIDTH-1:0] cur_code;
  logic                      cur_fire;

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NUM_NEURON; i++) begin
        snap_reg[i] <= spikes_in[i*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
      end
    end
  end

  assign cur_code = snap_reg[ptr];
  assign cur_fire = is_fire(cur_code);

  rr_scan_ptr #(
    .ID_W(NEURON_ID_WIDTH)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .eff_active (eff_active),
    .load       (load),
    .step       (step),
    .hit        (hit_take),
    .ptr        (ptr),
    .exhausted  (exhausted)
  );

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    hit_take   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (en_network) begin
          state_next = ST_SCAN;
          load       = 1'b1;
        end
      end
      ST_SCAN: begin
        // Dropping the request aborts the round silently; everything the
        // neurons can see (spike_out, winner_valid) and the round-robin
        // start pointer stay untouched.
        if (!en_network) begin
          state_next = ST_IDLE;
        end else if (scan_empty) begin
          state_next = ST_DONE;
        end else if (cur_fire) begin
          state_next = ST_DONE;
          hit_take   = 1'b1;
        end else if (exhausted) begin
          state_next = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!en_network) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registered state and outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      spike_out_reg    <= '0;
      networkDone_reg  <= 1'b0;
      winner_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      busy_reg        <= (state_next != ST_IDLE);
      // Pulse follows the DONE state by one cycle; spike_out is already
      // settled by then, so neurons sample a stable word after the pulse.
      networkDone_reg <= (state_reg == ST_DONE);
      if ((state_reg == ST_SCAN) && (state_next == ST_DONE)) begin
        spike_out_reg    <= hit_take ? {cur_code, ptr} : '0;
        winner_valid_reg <= hit_take;
      end
    end
  end

  assign spike_out    = spike_out_reg;
  assign networkDone  = networkDone_reg;
  assign winner_valid = winner_valid_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_spike_arbiter.sv
module tb_spike_arbiter;

  localparam int N = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_network;
  logic [2*N-1:0] spikes_in;
  logic [8:0]    active_neuron;
  logic [10:0]   spike_out;
  logic          networkDone;
  logic          winner_valid;
  logic          busy;

  always #5 clk = ~clk;

  spike_arbiter #(
    .TEN_DATA_WIDTH  (2),
    .NUM_NEURON      (N),
    .NEURON_ID_WIDTH (9)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en_network    (en_network),
    .spikes_in     (spikes_in),
    .active_neuron (active_neuron),
    .spike_out     (spike_out),
    .networkDone   (networkDone),
    .winner_valid  (winner_valid),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [1:0] codes [N];
  int m_start;

  typedef struct {
    int         act;
    int         ia;
    logic [1:0] ca;
    int         ib;
    logic [1:0] cb;
    logic [10:0] eout;
    logic       ev;
    int         elat;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_codes();
    for (int i = 0; i < N; i++) codes[i] = 2'd0;
  endtask

  task automatic load_codes();
    for (int i = 0; i < N; i++) spikes_in[2*i +: 2] = codes[i];
  endtask

  // Reference: search the active ring from the remembered start for the
  // first code 1/2; latency is scan position + 2 (or full ring + 1).
  task automatic model(input int act, output logic [10:0] o, output logic v, output int lat);
    int  eff;
    int  s0;
    int  idx;
    bit  found;
    eff   = (act < N) ? act : N;
    o     = '0;
    v     = 1'b0;
    found = 1'b0;
    lat   = (eff == 0) ? 2 : eff + 1;
    if (eff > 0) begin
      s0 = (m_start >= eff) ? 0 : m_start;
      for (int j = 0; j < eff && !found; j++) begin
        idx = (s0 + j) % eff;
        if (codes[idx] == 2'd1 || codes[idx] == 2'd2) begin
          found   = 1'b1;
          o       = {codes[idx], 9'(idx)};
          v       = 1'b1;
          lat     = j + 2;
          m_start = (idx + 1) % eff;
        end
      end
    end
  endtask

  // Runs one round from IDLE, called just after a falling edge.
  task automatic do_round(input int act, input bit keep_en,
                          output int lat, output logic [10:0] o, output logic v);
    bit seen;
    seen = 1'b0;
    load_codes();
    active_neuron = act[8:0];
    en_network    = 1'b1;
    @(posedge clk);              // edge k: request accepted
    @(negedge clk);
    check("busy_in_round", busy, 1);
    for (int i = 0; i < 2*N; i += 32) spikes_in[i +: 32] = $urandom();  // must be ignored
    lat = 0;
    o   = '0;
    v   = 1'b0;
    while (!seen && lat < 600) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (networkDone) begin
        seen = 1'b1;
        o    = spike_out;
        v    = winner_valid;
      end
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL round_timeout: got no networkDone expected pulse within 600 cycles (act=%0d)", act);
    end else begin
      @(negedge clk);
      check("done_one_cycle", networkDone, 0);
    end
    if (!keep_en) begin
      en_network = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] mo;
    logic        mv;
    int          ml;
    logic [10:0] o;
    logic        v;
    int          lat;
    int          act;
    int          nh;
    int          pos;

    reset         = 1'b1;
    en_network    = 1'b0;
    spikes_in     = '0;
    active_neuron = '0;
    m_start       = 0;
    repeat (3) @(negedge clk);
    check("reset_spike_out", spike_out, 0);
    check("reset_done", networkDone, 0);
    check("reset_valid", winner_valid, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // ---------------- table-driven rounds (start pointer carries over) ----
    tbl[0] = '{4, 2, 2'd2, -1, 2'd0, 11'h402, 1'b1, 4};
    tbl[1] = '{4, 0, 2'd1,  2, 2'd2, 11'h200, 1'b1, 3};
    tbl[2] = '{8, 5, 2'd3, -1, 2'd0, 11'h000, 1'b0, 9};
    tbl[3] = '{8, 1, 2'd1,  5, 2'd3, 11'h201, 1'b1, 2};
    tbl[4] = '{0, 0, 2'd1, -1, 2'd0, 11'h000, 1'b0, 2};
    tbl[5] = '{8, 4, 2'd2, -1, 2'd0, 11'h404, 1'b1, 4};
    tbl[6] = '{3, 0, 2'd1,  2, 2'd2, 11'h200, 1'b1, 2};
    tbl[7] = '{3, 1, 2'd3,  2, 2'd1, 11'h202, 1'b1, 3};
    tbl[8] = '{3, 0, 2'd2, -1, 2'd0, 11'h400, 1'b1, 2};

    for (int r = 0; r < 9; r++) begin
      clear_codes();
      if (tbl[r].act < N) codes[tbl[r].act] = 2'd1;   // decoy just outside the ring
      if (tbl[r].ia >= 0) codes[tbl[r].ia] = tbl[r].ca;
      if (tbl[r].ib >= 0) codes[tbl[r].ib] = tbl[r].cb;
      model(tbl[r].act, mo, mv, ml);
      do_round(tbl[r].act, 1'b0, lat, o, v);
      $display("row %0d act=%0d lat=%0d out=0x%0h valid=%0b", r, tbl[r].act, lat, o, v);
      check("tbl_latency", lat, tbl[r].elat);
      check("tbl_spike_out", o, tbl[r].eout);
      check("tbl_valid", v, tbl[r].ev);
    end

    // ---------------- abort: request dropped in scan step 2 ---------------
    clear_codes();
    codes[6] = 2'd1;
    load_codes();
    active_neuron = 9'd8;
    en_network    = 1'b1;
    repeat (3) @(posedge clk);   // edges k, k+1 (step 0), k+2 (step 1)
    @(negedge clk);
    en_network = 1'b0;           // seen at step 2
    repeat (5) begin
      @(negedge clk);
      check("abort_no_done", networkDone, 0);
      check("abort_hold_out", spike_out, tbl[8].eout);
      check("abort_hold_valid", winner_valid, 1);
    end
    check("abort_idle", busy, 0);
    $display("abort sequence done");

    model(8, mo, mv, ml);
    do_round(8, 1'b0, lat, o, v);
    $display("post-abort round lat=%0d out=0x%0h valid=%0b", lat, o, v);
    check("post_abort_lat", lat, ml);
    check("post_abort_out", o, mo);
    check("post_abort_valid", v, mv);

    // ---------------- reset in the middle of a scan -----------------------
    load_codes();
    active_neuron = 9'd8;
    en_network    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_out", spike_out, 0);
    check("midreset_valid", winner_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", networkDone, 0);
    @(negedge clk);
    reset      = 1'b0;
    en_network = 1'b0;
    m_start    = 0;
    @(negedge clk);
    $display("mid-scan reset done");

    // ---------------- request held high after completion ------------------
    clear_codes();
    codes[1] = 2'd2;
    model(4, mo, mv, ml);
    do_round(4, 1'b1, lat, o, v);
    $display("held round lat=%0d out=0x%0h valid=%0b", lat, o, v);
    check("held_lat", lat, ml);
    check("held_out", o, mo);
    repeat (6) begin
      @(negedge clk);
      check("held_no_second_done", networkDone, 0);
      check("held_out_stable", spike_out, mo);
      check("held_busy", busy, 1);
    end
    en_network = 1'b0;
    @(negedge clk);
    codes[3] = 2'd1;
    model(4, mo, mv, ml);
    do_round(4, 1'b0, lat, o, v);
    $display("re-armed round lat=%0d out=0x%0h valid=%0b", lat, o, v);
    check("rearm_lat", lat, ml);
    check("rearm_out", o, mo);
    check("rearm_valid", v, mv);

    // ---------------- randomized rounds vs reference ----------------------
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(0, 6))
        0:       act = 0;
        1:       act = 1;
        2:       act = 2;
        3:       act = 511;
        4:       act = int'($urandom_range(1, 511));
        default: act = int'($urandom_range(1, 40));
      endcase
      for (int i = 0; i < N; i++) begin
        if (i >= act) codes[i] = 2'($urandom_range(0, 3));
        else          codes[i] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'd0;
      end
      nh = int'($urandom_range(0, 3));
      if (act > 0) begin
        for (int h = 0; h < nh; h++) begin
          pos = int'($urandom_range(0, act - 1));
          codes[pos] = 2'($urandom_range(1, 2));
        end
      end
      model(act, mo, mv, ml);
      do_round(act, 1'b0, lat, o, v);
      $display("rand %0d act=%0d lat=%0d/%0d out=0x%0h/0x%0h", r, act, lat, ml, o, mo);
      check("rand_lat", lat, ml);
      check("rand_out", o, mo);
      check("rand_valid", v, mv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
